mskand_hpc2_pipe: RTL and testbench

//  W-bit, D-share masked AND (HPC2-style, PINI at order D-1) with a 2-stage valid/ready pipeline
//  and a handshaked randomness port. Operands and their fresh randomness arrive in one aligned

---
 rtl/mskand_pkg.sv | 26 ++
 rtl/mskand_hpc2_lane.sv | 92 +++++++++
 rtl/mskand_hpc2_pipe.sv | 84 ++++++++
 tb/tb_mskand_hpc2_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mskand_pkg.sv
// rtl/mskand_pkg.sv - index helpers shared by the masked AND pipeline
// Purpose: pure index arithmetic for share packing and randomness pair
// numbering. No ports; imported by mskand_hpc2_lane and mskand_hpc2_pipe.
package mskand_pkg;

  // Index of unordered pair (i<j) among D shares, row-major over the upper triangle.
  function automatic int PIDX(input int i, input int j, input int d);
    return i * d - i * (i + 1) / 2 + (j - 1 - i);
  endfunction

  // Random bits consumed per beat for D shares and W lanes.
  function automatic int NRND(input int d, input int w);
    return w * d * (d - 1) / 2;
  endfunction

  // Position of share i, bit lane k in a packed D*W sharing.
  function automatic int SIDX(input int i, input int k, input int w);
    return i * w + k;
  endfunction

  // Dense index of ordered pair (i,j), j!=i, so no diagonal storage is needed.
  function automatic int OIDX(input int i, input int j, input int d);
    return i * (d - 1) + ((j < i) ? j : j - 1);
  endfunction

endpackage

// File: rtl/mskand_hpc2_lane.sv
// rtl/mskand_hpc2_lane.sv - one bit lane of the two-stage HPC2 masked AND
// Purpose: D-share AND of one bit lane with registered cross terms.
// Ports: clk, rst_n (async active-low); ld1 loads stage 1, ld2 loads stage 2;
//        a, b: D shares; r: D*(D-1)/2 pair randoms; out: D shares of a&b,
//        combinational from stage-2 flops only.
module mskand_hpc2_lane
  import mskand_pkg::*;
#(
  parameter int D = 2,
  localparam int NP = D * (D - 1) / 2,
  localparam int NO = D * (D - 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld1,
  input  logic          ld2,
  input  logic [D-1:0]  a,
  input  logic [D-1:0]  b,
  input  logic [NP-1:0] r,
  output logic [D-1:0]  out
);

  (* keep = "true" *) logic [D-1:0]  a1_q, b1_q, p_q, p_d;
  (* keep = "true" *) logic [NP-1:0] r1_q;
  (* keep = "true" *) logic [NO-1:0] v_q, v_d, u_q, u_d, w_q, w_d;

  // v_ij = b_j ^ r_ij only mixes B shares with randomness; A meets the
  // foreign B share only after this value has been registered.
  always_comb begin
    v_d = '0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        if (j != i) begin
          v_d[OIDX(i, j, D)] = b[j] ^ r[PIDX((i < j) ? i : j, (i < j) ? j : i, D)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q <= '0;
      b1_q <= '0;
      r1_q <= '0;
      v_q  <= '0;
    end else if (ld1) begin
      a1_q <= a;
      b1_q <= b;
      r1_q <= r;
      v_q  <= v_d;
    end
  end

  always_comb begin
    p_d = a1_q & b1_q;
    u_d = '0;
    w_d = '0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        if (j != i) begin
          u_d[OIDX(i, j, D)] = ~a1_q[i] & r1_q[PIDX((i < j) ? i : j, (i < j) ? j : i, D)];
          w_d[OIDX(i, j, D)] = a1_q[i] & v_q[OIDX(i, j, D)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      u_q <= '0;
      w_q <= '0;
    end else if (ld2) begin
      p_q <= p_d;
      u_q <= u_d;
      w_q <= w_d;
    end
  end

  // u_ij ^ w_ij = r_ij ^ a_i&b_j; each r_ij shows up in shares i and j and cancels.
  always_comb begin
    out = p_q;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        if (j != i) begin
          out[i] = out[i] ^ u_q[OIDX(i, j, D)] ^ w_q[OIDX(i, j, D)];
        end
      end
    end
  end

endmodule

// File: rtl/mskand_hpc2_pipe.sv
// rtl/mskand_hpc2_pipe.sv - W-lane D-share masked AND with valid/ready pipeline
// Purpose: W parallel HPC2 AND lanes behind a 2-stage valid/ready pipeline
// with a handshaked randomness port.
// Ports: clk, rst_n (async active-low), flush (sync valid clear);
//        in_valid/in_ready with ina, inb (share i bit k at i*W+k);
//        rnd_valid/rnd_ready with rnd (lane k pair p at k*D*(D-1)/2+p);
//        out_valid/out_ready with out (same packing as ina).
module mskand_hpc2_pipe
  import mskand_pkg::*;
#(
  parameter int D = 2,
  parameter int W = 1,
  localparam int N_RND = NRND(D, W),
  localparam int NP = D * (D - 1) / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D*W-1:0]   ina,
  input  logic [D*W-1:0]   inb,
  input  logic [N_RND-1:0] rnd,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic [D*W-1:0]   out,
  output logic             out_valid,
  input  logic             out_ready
);

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic accept, adv2, pop;

  // Flush wins over every transfer in its cycle; data flops keep their contents.
  always_comb begin
    adv2      = s1_valid_q & (~s2_valid_q | out_ready) & ~flush;
    in_ready  = ~s1_valid_q | adv2;
    rnd_ready = in_valid & in_ready & ~flush;
    accept    = rnd_ready & rnd_valid;
    pop       = s2_valid_q & out_ready;

    s1_valid_d = s1_valid_q;
    if (flush)       s1_valid_d = 1'b0;
    else if (accept) s1_valid_d = 1'b1;
    else if (adv2)   s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (flush)     s2_valid_d = 1'b0;
    else if (adv2) s2_valid_d = 1'b1;
    else if (pop)  s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_valid = s2_valid_q;

  for (genvar k = 0; k < W; k++) begin : g_lane
    logic [D-1:0] a_k, b_k, o_k;
    for (genvar i = 0; i < D; i++) begin : g_sh
      assign a_k[i] = ina[SIDX(i, k, W)];
      assign b_k[i] = inb[SIDX(i, k, W)];
      assign out[SIDX(i, k, W)] = o_k[i];
    end
    mskand_hpc2_lane #(.D(D)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld1   (accept),
      .ld2   (adv2),
      .a     (a_k),
      .b     (b_k),
      .r     (rnd[k*NP +: NP]),
      .out   (o_k)
    );
  end

endmodule

// File: tb/tb_mskand_hpc2_pipe.sv
// tb/tb_mskand_hpc2_pipe.sv - self-checking bench for mskand_hpc2_pipe
module tb_mskand_hpc2_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // D=2, W=1 instance
  logic       flush2 = 0, iv2 = 0, rv2 = 0, ordy2 = 1;
  logic       ir2, rr2, ov2;
  logic [1:0] ina2 = 0, inb2 = 0, out2;
  logic [0:0] rnd2 = 0;

  // D=3, W=4 instance
  logic        flush3 = 0, iv3 = 0, rv3 = 0, ordy3 = 1;
  logic        ir3, rr3, ov3;
  logic [11:0] ina3 = 0, inb3 = 0, rnd3 = 0, out3;

  mskand_hpc2_pipe #(.D(2), .W(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(iv2), .in_ready(ir2),
    .ina(ina2), .inb(inb2), .rnd(rnd2), .rnd_valid(rv2), .rnd_ready(rr2),
    .out(out2), .out_valid(ov2), .out_ready(ordy2));

  mskand_hpc2_pipe #(.D(3), .W(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .in_valid(iv3), .in_ready(ir3),
    .ina(ina3), .inb(inb3), .rnd(rnd3), .rnd_valid(rv3), .rnd_ready(rr3),
    .out(out3), .out_valid(ov3), .out_ready(ordy3));

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] unmask3(input logic [11:0] s);
    return s[3:0] ^ s[7:4] ^ s[11:8];
  endfunction

  // Scoreboard for the D=3 instance: plain A&B of every accepted beat, in order.
  logic [3:0] q[$];
  int acc_cnt = 0, pop_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (ov3 && ordy3) begin
        pop_cnt++;
        chk("sb_result", {27'd0, 1'b1, unmask3(out3)},
            {27'd0, q.size() != 0, (q.size() != 0) ? q[0] : 4'h0});
        if (q.size() != 0) void'(q.pop_front());
      end
      if (flush3) q.delete();
      else if (iv3 && rv3 && ir3) begin
        q.push_back(unmask3(ina3) & unmask3(inb3));
        acc_cnt++;
      end
    end
  end

  task automatic new_beat3();
    ina3 = 12'($urandom());
    inb3 = 12'($urandom());
    rnd3 = 12'($urandom());
  endtask

  task automatic drain3(input string name);
    iv3 = 0;
    ordy3 = 1;
    for (int c = 0; c < 20; c++) begin
      if (q.size() == 0 && !ov3) break;
      tick();
    end
    chk(name, q.size(), 0);
  endtask

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       r;
    logic       exp;
  } vec_t;
  vec_t vec[32];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, p0, bad, sent, cyc;
    logic have;
    logic [11:0] snap;

    for (int i = 0; i < 32; i++) begin
      vec[i].a   = 2'(i >> 3);
      vec[i].b   = 2'(i >> 1);
      vec[i].r   = 1'(i);
      vec[i].exp = (vec[i].a[0] ^ vec[i].a[1]) & (vec[i].b[0] ^ vec[i].b[1]);
    end

    // Reset state
    iv3 = 1;
    #3;
    chk("rst_out_valid", ov3, 0);
    chk("rst_out", out3, 0);
    chk("rst_in_ready", ir3, 1);
    chk("rst_rnd_ready", rr3, 1);
    chk("rst_d2_out_valid", ov2, 0);
    chk("rst_d2_in_ready", ir2, 1);
    iv3 = 0;
    #2;
    tick();
    rst_n = 1;
    tick();

    // Test 1: exhaustive D=2 table
    for (int v = 0; v < 32; v++) begin
      ina2 = vec[v].a; inb2 = vec[v].b; rnd2 = vec[v].r;
      iv2 = 1; rv2 = 1;
      tick();
      iv2 = 0; rv2 = 0;
      chk("t1_lat_early", ov2, 0);
      tick();
      chk("t1_lat_valid", ov2, 1);
      chk("t1_unmasked", out2[0] ^ out2[1], vec[v].exp);
      tick();
    end

    // Test 2: 1000 back-to-back random beats
    a0 = acc_cnt; p0 = pop_cnt; bad = 0;
    ordy3 = 1; rv3 = 1; iv3 = 1;
    for (int i = 0; i < 1000; i++) begin
      new_beat3();
      tick();
      if (i >= 1 && !ov3) bad++;
    end
    drain3("t2_drain");
    chk("t2_accepts", acc_cnt - a0, 1000);
    chk("t2_results", pop_cnt - p0, 1000);
    chk("t2_bubbles", bad, 0);

    // Random back-pressure and randomness starvation
    sent = 0; cyc = 0; have = 0;
    while (sent < 300 && cyc < 3000) begin
      if (!have) begin new_beat3(); have = 1; end
      iv3 = 1;
      rv3 = ($urandom_range(0, 3) != 0);
      ordy3 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (iv3 && rv3 && ir3) begin sent++; have = 0; end
      tick();
      cyc++;
    end
    chk("t7_sent", sent, 300);
    drain3("t7_drain");

    // Test 3: back-pressure with two beats in flight
    ordy3 = 0; rv3 = 1; iv3 = 1;
    new_beat3(); tick();
    new_beat3(); tick();
    iv3 = 0;
    chk("t3_full_valid", ov3, 1);
    snap = out3;
    for (int c = 0; c < 5; c++) begin
      new_beat3();
      tick();
      chk("t3_in_ready", ir3, 0);
      chk("t3_out_stable", out3, snap);
      chk("t3_out_valid", ov3, 1);
    end
    p0 = pop_cnt;
    drain3("t3_drain");
    chk("t3_results", pop_cnt - p0, 2);

    // Test 4: randomness not available
    iv3 = 1; rv3 = 0; new_beat3();
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t4_rnd_ready", rr3, 1);
      tick();
      chk("t4_no_out", ov3, 0);
    end
    rv3 = 1;
    tick();
    iv3 = 0; rv3 = 0;
    chk("t4_lat_early", ov3, 0);
    tick();
    chk("t4_lat_valid", ov3, 1);
    drain3("t4_drain");

    // Test 5: async reset with both stages valid
    ordy3 = 0; rv3 = 1; iv3 = 1;
    new_beat3(); tick();
    new_beat3(); tick();
    iv3 = 0;
    chk("t5_full_valid", ov3, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t5_rst_valid", ov3, 0);
    chk("t5_rst_out", out3, 0);
    chk("t5_rst_in_ready", ir3, 1);
    iv3 = 1; rv3 = 0;
    #1;
    chk("t5_rst_rnd_ready", rr3, 1);
    iv3 = 0;
    tick();
    rst_n = 1;
    ordy3 = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_no_stale", ov3, 0);
    end

    // Test 6: flush with both stages valid and a beat offered
    ordy3 = 0; rv3 = 1; iv3 = 1;
    new_beat3(); tick();
    new_beat3(); tick();
    new_beat3();
    flush3 = 1;
    #2;
    chk("t6_rnd_ready", rr3, 0);
    chk("t6_in_ready", ir3, 0);
    tick();
    flush3 = 0; iv3 = 0; rv3 = 0;
    chk("t6_flushed", ov3, 0);
    ordy3 = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_no_accept", ov3, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
